// File: rtl/bhg_write_sink_pkg.sv
// Shared types and constants for the pixel write-port sink: FSM states,
// byte-lane geometry and the entry layout held by the command FIFO.
package bhg_write_sink_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OPEN = 1'b1
    } sink_state_t;

    localparam int LANE_BYTES   = 4;
    localparam int WORD_BYTES   = 16;
    localparam int ENTRY_ADDR_W = 32;

    // The address field is sized for the widest supported port; the top
    // only uses the low PORT_ADDR_SIZE-4 bits.
    typedef struct packed {
        logic [ENTRY_ADDR_W-1:0] addr;
        logic [WORD_BYTES*8-1:0] data;
        logic [WORD_BYTES-1:0]   mask;
    } fifo_entry_t;

endpackage

// File: rtl/bhg_fwft_fifo.sv
// Register-based first-word-fall-through FIFO. The head entry is visible on
// dout whenever empty=0; pop advances it on the next clock edge.
module bhg_fwft_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CNT_W'(DEPTH));
    assign count   = count_reg;
    assign dout    = mem_reg[rd_ptr_reg];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else if (do_push) begin
            mem_reg[wr_ptr_reg] <= din;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            count_reg <= count_reg + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/bhg_write_port_sink.sv
// Gathers 32-bit masked pixel writes into 128-bit words and issues them as
// DDR3 write commands through a small first-word-fall-through queue.
module bhg_write_port_sink
    import bhg_write_sink_pkg::*;
#(
    parameter int PORT_ADDR_SIZE = 25,
    parameter int FIFO_DEPTH     = 4,
    parameter int FLUSH_TIMEOUT  = 16
) (
    input  logic                        CLK,
    input  logic                        reset_n,
    input  logic                        write_req_in,
    input  logic [PORT_ADDR_SIZE-1:0]   write_adr_in,
    input  logic [31:0]                 write_data_in,
    input  logic [3:0]                  write_mask_in,
    input  logic                        flush_in,
    output logic                        write_busy_out,
    output logic                        CMD_ena,
    output logic [PORT_ADDR_SIZE-5:0]   CMD_addr,
    output logic [127:0]                CMD_wdata,
    output logic [15:0]                 CMD_wmask,
    input  logic                        CMD_busy
);

    localparam int WA_W    = PORT_ADDR_SIZE - 4;
    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int TIMER_W = $clog2(FLUSH_TIMEOUT + 1);
    localparam int WORD_W  = WORD_BYTES * 8;

    sink_state_t          state_reg,  state_next;
    logic [WORD_W-1:0]    word_reg,   word_next;
    logic [WORD_BYTES-1:0] mask_reg,  mask_next;
    logic [WA_W-1:0]      addr_reg,   addr_next;
    logic [TIMER_W-1:0]   timer_reg,  timer_next;
    logic                 busy_reg,   busy_next;

    logic [1:0]           req_lane;
    logic [WA_W-1:0]      req_word;
    logic                 accept;
    logic                 req_has_bytes;
    logic                 addr_match;
    logic                 timer_expired;

    logic [WORD_W-1:0]     merge_word;
    logic [WORD_W-1:0]     fresh_word;
    logic [WORD_BYTES-1:0] merge_mask;
    logic [WORD_BYTES-1:0] fresh_mask;

    fifo_entry_t          push_entry;
    fifo_entry_t          head_entry;
    logic                 push_req;
    logic                 pop_fire;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic [CNT_W-1:0]     fifo_count;
    logic [CNT_W-1:0]     count_next;

    logic                 unused_adr_lsbs;
    logic                 unused_head_addr;

    assign req_lane         = write_adr_in[3:2];
    assign req_word         = write_adr_in[PORT_ADDR_SIZE-1:4];
    assign accept           = write_req_in && !busy_reg;
    assign req_has_bytes    = (write_mask_in != 4'h0);
    assign addr_match       = (req_word == addr_reg);
    assign timer_expired    = (timer_reg >= TIMER_W'(FLUSH_TIMEOUT - 1));
    assign unused_adr_lsbs  = ^write_adr_in[1:0];
    assign unused_head_addr = ^head_entry.addr;

    // Per-byte steering of the incoming lane into either the open word
    // (merge) or an all-zero word (fresh open).
    for (genvar gi = 0; gi < WORD_BYTES; gi++) begin : g_byte
        localparam int LANE = gi / LANE_BYTES;
        localparam int SUB  = gi % LANE_BYTES;
        logic byte_hit;

        assign byte_hit = (req_lane == 2'(LANE)) && write_mask_in[SUB];
        assign merge_word[gi*8 +: 8] = byte_hit ? write_data_in[SUB*8 +: 8] : word_reg[gi*8 +: 8];
        assign fresh_word[gi*8 +: 8] = byte_hit ? write_data_in[SUB*8 +: 8] : 8'h00;
        assign merge_mask[gi]        = byte_hit || mask_reg[gi];
        assign fresh_mask[gi]        = byte_hit;
    end

    always_comb begin
        state_next      = state_reg;
        word_next       = word_reg;
        mask_next       = mask_reg;
        addr_next       = addr_reg;
        timer_next      = timer_reg;
        push_req        = 1'b0;
        push_entry.addr = ENTRY_ADDR_W'(addr_reg);
        push_entry.data = word_reg;
        push_entry.mask = mask_reg;

        case (state_reg)
            ST_IDLE: begin
                timer_next = '0;
                if (accept && req_has_bytes) begin
                    word_next  = fresh_word;
                    mask_next  = fresh_mask;
                    addr_next  = req_word;
                    state_next = ST_OPEN;
                end
            end
            ST_OPEN: begin
                if (accept && req_has_bytes && !addr_match) begin
                    // Retire the old word and start the new one in one edge;
                    // busy guarantees a free FIFO slot here.
                    push_req   = 1'b1;
                    word_next  = fresh_word;
                    mask_next  = fresh_mask;
                    addr_next  = req_word;
                    timer_next = '0;
                end else if (accept && req_has_bytes) begin
                    timer_next = '0;
                    if ((&merge_mask) || flush_in) begin
                        push_req        = 1'b1;
                        push_entry.data = merge_word;
                        push_entry.mask = merge_mask;
                        state_next      = ST_IDLE;
                    end else begin
                        word_next = merge_word;
                        mask_next = merge_mask;
                    end
                end else if (accept) begin
                    timer_next = '0;
                    if (flush_in) begin
                        push_req   = 1'b1;
                        state_next = ST_IDLE;
                    end
                end else if (flush_in || timer_expired) begin
                    if (!fifo_full) begin
                        push_req   = 1'b1;
                        state_next = ST_IDLE;
                        timer_next = '0;
                    end else if (!timer_expired) begin
                        timer_next = timer_reg + TIMER_W'(1);
                    end
                end else begin
                    timer_next = timer_reg + TIMER_W'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign pop_fire   = !fifo_empty && !CMD_busy;
    assign count_next = fifo_count + CNT_W'(push_req) - CNT_W'(pop_fire);
    assign busy_next  = (count_next >= CNT_W'(FIFO_DEPTH - 1));

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= ST_IDLE;
            word_reg  <= '0;
            mask_reg  <= '0;
            addr_reg  <= '0;
            timer_reg <= '0;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            word_reg  <= word_next;
            mask_reg  <= mask_next;
            addr_reg  <= addr_next;
            timer_reg <= timer_next;
            busy_reg  <= busy_next;
        end
    end

    bhg_fwft_fifo #(
        .WIDTH ($bits(fifo_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .rst_n (reset_n),
        .push  (push_req),
        .din   (push_entry),
        .pop   (pop_fire),
        .dout  (head_entry),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    assign write_busy_out = busy_reg;
    assign CMD_ena        = !fifo_empty;
    assign CMD_addr       = head_entry.addr[WA_W-1:0];
    assign CMD_wdata      = head_entry.data;
    assign CMD_wmask      = head_entry.mask;

endmodule

// File: tb/tb_bhg_write_port_sink.sv
// Directed and randomized bench for bhg_write_port_sink, checked against a
// byte-level reference model of the write gathering and command queue.
module tb_bhg_write_port_sink;

    localparam int AS    = 25;
    localparam int WA    = AS - 4;
    localparam int DEPTH = 4;
    localparam int FT    = 16;

    logic            CLK = 1'b0;
    logic            reset_n = 1'b1;
    logic            write_req_in = 1'b0;
    logic [AS-1:0]   write_adr_in = '0;
    logic [31:0]     write_data_in = '0;
    logic [3:0]      write_mask_in = '0;
    logic            flush_in = 1'b0;
    logic            CMD_busy = 1'b0;
    logic            write_busy_out;
    logic            CMD_ena;
    logic [WA-1:0]   CMD_addr;
    logic [127:0]    CMD_wdata;
    logic [15:0]     CMD_wmask;

    always #5 CLK = ~CLK;

    bhg_write_port_sink #(
        .PORT_ADDR_SIZE (AS),
        .FIFO_DEPTH     (DEPTH),
        .FLUSH_TIMEOUT  (FT)
    ) dut (
        .CLK            (CLK),
        .reset_n        (reset_n),
        .write_req_in   (write_req_in),
        .write_adr_in   (write_adr_in),
        .write_data_in  (write_data_in),
        .write_mask_in  (write_mask_in),
        .flush_in       (flush_in),
        .write_busy_out (write_busy_out),
        .CMD_ena        (CMD_ena),
        .CMD_addr       (CMD_addr),
        .CMD_wdata      (CMD_wdata),
        .CMD_wmask      (CMD_wmask),
        .CMD_busy       (CMD_busy)
    );

    typedef struct {
        logic [WA-1:0] addr;
        logic [127:0]  data;
        logic [15:0]   mask;
    } cmd_t;

    // Reference model: open word as bytes + enables, expected command queue.
    cmd_t          q[$];
    bit            m_open;
    logic [WA-1:0] m_addr;
    logic [7:0]    m_bytes[16];
    bit            m_en[16];
    int            m_idle;
    bit            m_busy;

    int pass_cnt  = 0;
    int chk_cnt   = 0;
    int fail_cnt  = 0;
    int dut_pops  = 0;
    int model_pop = 0;
    int cb_hold   = 0;
    bit saw_busy  = 0;

    task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic m_clear();
        for (int i = 0; i < 16; i++) begin
            m_bytes[i] = 8'h00;
            m_en[i]    = 1'b0;
        end
    endtask

    task automatic m_write(int lane, logic [31:0] d, logic [3:0] m);
        for (int b = 0; b < 4; b++) begin
            if (m[b]) begin
                m_bytes[lane*4 + b] = d[b*8 +: 8];
                m_en[lane*4 + b]    = 1'b1;
            end
        end
    endtask

    function automatic bit m_complete();
        for (int i = 0; i < 16; i++) begin
            if (!m_en[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic cmd_t m_snapshot();
        cmd_t c;
        c.addr = m_addr;
        for (int i = 0; i < 16; i++) begin
            c.data[i*8 +: 8] = m_bytes[i];
            c.mask[i]        = m_en[i];
        end
        return c;
    endfunction

    task automatic model_edge();
        bit            acc;
        bit            pop;
        bit            do_push;
        cmd_t          pe;
        logic [WA-1:0] wa;
        int            lane;
        pop     = (q.size() != 0) && !CMD_busy;
        acc     = write_req_in && !m_busy;
        wa      = write_adr_in[AS-1:4];
        lane    = int'(write_adr_in[3:2]);
        do_push = 1'b0;
        if (acc && write_mask_in != 4'h0) begin
            if (!m_open) begin
                m_clear();
                m_write(lane, write_data_in, write_mask_in);
                m_addr = wa;
                m_open = 1'b1;
            end else if (wa != m_addr) begin
                pe = m_snapshot();
                do_push = 1'b1;
                m_clear();
                m_write(lane, write_data_in, write_mask_in);
                m_addr = wa;
            end else begin
                m_write(lane, write_data_in, write_mask_in);
                if (m_complete() || flush_in) begin
                    pe = m_snapshot();
                    do_push = 1'b1;
                    m_open = 1'b0;
                end
            end
            m_idle = 0;
        end else if (acc) begin
            if (m_open && flush_in) begin
                pe = m_snapshot();
                do_push = 1'b1;
                m_open = 1'b0;
            end
            m_idle = 0;
        end else if (m_open) begin
            m_idle = (m_idle < FT) ? m_idle + 1 : FT;
            if ((flush_in || m_idle >= FT) && q.size() < DEPTH) begin
                pe = m_snapshot();
                do_push = 1'b1;
                m_open = 1'b0;
                m_idle = 0;
            end
        end
        if (pop) begin
            $display("cmd %0d addr=%h wmask=%h wdata=%h", model_pop, q[0].addr, q[0].mask, q[0].data);
            model_pop++;
            void'(q.pop_front());
        end
        if (do_push) q.push_back(pe);
        m_busy = (q.size() >= DEPTH - 1);
    endtask

    task automatic check_outputs();
        chk("cmd_ena", 128'(CMD_ena), 128'(q.size() != 0));
        chk("write_busy", 128'(write_busy_out), 128'(m_busy));
        if (write_busy_out) saw_busy = 1'b1;
        if (q.size() != 0) begin
            chk("cmd_addr", 128'(CMD_addr), 128'(q[0].addr));
            chk("cmd_wdata", CMD_wdata, q[0].data);
            chk("cmd_wmask", 128'(CMD_wmask), 128'(q[0].mask));
        end
    endtask

    task automatic step();
        if (CMD_ena && !CMD_busy) dut_pops++;
        @(posedge CLK);
        model_edge();
        #1;
        check_outputs();
        if (cb_hold > 0) begin
            cb_hold--;
            CMD_busy = (cb_hold > 0);
        end
    endtask

    task automatic wr(logic [AS-1:0] a, logic [31:0] d, logic [3:0] m);
        bit done;
        done          = 1'b0;
        write_req_in  = 1'b1;
        write_adr_in  = a;
        write_data_in = d;
        write_mask_in = m;
        for (int n = 0; n < 200 && !done; n++) begin
            done = !m_busy;
            step();
        end
        chk("wr_accept", 128'(done), 128'(1));
        write_req_in = 1'b0;
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        #1;
        chk("rst_ena", 128'(CMD_ena), 128'(0));
        chk("rst_busy", 128'(write_busy_out), 128'(0));
        chk("rst_addr", 128'(CMD_addr), 128'(0));
        chk("rst_wdata", CMD_wdata, 128'(0));
        chk("rst_wmask", 128'(CMD_wmask), 128'(0));
        q.delete();
        m_open = 1'b0;
        m_busy = 1'b0;
        m_idle = 0;
        m_clear();
        @(posedge CLK);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        int               base;
        logic [WA-1:0]    words[4];
        logic [WA-1:0]    w;
        logic [1:0]       ln;
        words[0] = 21'h0;
        words[1] = 21'h1;
        words[2] = 21'h2;
        words[3] = 21'h1234;
        m_addr = '0;
        m_clear();

        #2;
        pulse_reset();

        // Four full lanes -> one command one cycle after the last write.
        wr(25'h100, 32'h1, 4'hF);
        wr(25'h104, 32'h2, 4'hF);
        wr(25'h108, 32'h3, 4'hF);
        wr(25'h10C, 32'h4, 4'hF);
        chk("r22_ena", 128'(CMD_ena), 128'(1));
        chk("r22_addr", 128'(CMD_addr), 128'h10);
        chk("r22_wdata", CMD_wdata, 128'h00000004_00000003_00000002_00000001);
        chk("r22_wmask", 128'(CMD_wmask), 128'hFFFF);
        repeat (3) step();

        // Partial word flushed by the idle timer.
        wr(25'h200, 32'hAABBCCDD, 4'h3);
        repeat (FT - 1) step();
        chk("r23_early", 128'(CMD_ena), 128'(0));
        step();
        chk("r23_ena", 128'(CMD_ena), 128'(1));
        chk("r23_addr", 128'(CMD_addr), 128'h20);
        chk("r23_wmask", 128'(CMD_wmask), 128'h3);
        chk("r23_wdata", 128'(CMD_wdata[15:0]), 128'hCCDD);
        repeat (2) step();

        // Address changes push, flush_in retires the last word.
        base = dut_pops;
        wr(25'h000, 32'h11, 4'hF);
        wr(25'h010, 32'h22, 4'hF);
        wr(25'h020, 32'h33, 4'hF);
        flush_in = 1'b1;
        step();
        flush_in = 1'b0;
        repeat (5) step();
        chk("r24_cmds", 128'(dut_pops - base), 128'(3));

        // Backpressure: ten full words streamed while CMD_busy is held.
        base     = dut_pops;
        saw_busy = 1'b0;
        CMD_busy = 1'b1;
        cb_hold  = 80;
        for (int wd = 0; wd < 10; wd++) begin
            for (int l = 0; l < 4; l++) begin
                wr(AS'(32'h1000 + wd*16 + l*4), 32'(wd*16 + l), 4'hF);
            end
        end
        while (cb_hold > 0) step();
        repeat (10) step();
        chk("r25_busy_seen", 128'(saw_busy), 128'(1));
        chk("r25_drained", 128'(dut_pops - base), 128'(10));

        // Reset with two queued words and an open one discards everything.
        CMD_busy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wr(AS'(32'h2000 + i*4), 32'(100 + i), 4'hF);
        end
        wr(25'h2040, 32'hDEAD, 4'h1);
        chk("r26_pre_ena", 128'(CMD_ena), 128'(1));
        pulse_reset();
        CMD_busy = 1'b0;
        base = dut_pops;
        repeat (30) step();
        chk("r26_no_cmds", 128'(dut_pops - base), 128'(0));

        // Randomized traffic, with quiet stretches that let the timer expire.
        for (int c = 0; c < 800; c++) begin
            if ((c % 200) >= 180) begin
                write_req_in = 1'b0;
                flush_in     = 1'b0;
            end else begin
                write_req_in = ($urandom_range(0, 99) < 60);
                flush_in     = ($urandom_range(0, 24) == 0);
            end
            w  = words[$urandom_range(0, 3)];
            ln = 2'($urandom_range(0, 3));
            write_adr_in  = {w, ln, 2'($urandom_range(0, 3))};
            write_data_in = $urandom;
            write_mask_in = ($urandom_range(0, 4) == 0) ? 4'h0 :
                            ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom_range(0, 15));
            CMD_busy = ($urandom_range(0, 2) == 0);
            step();
        end

        write_req_in = 1'b0;
        CMD_busy     = 1'b0;
        flush_in     = 1'b1;
        step();
        flush_in = 1'b0;
        repeat (30) step();
        chk("final_empty", 128'(CMD_ena), 128'(0));

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
